// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer: FSM states, LFSR shape, BCD digit format.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    TIMING,
    DONE,
    EARLY
  } state_t;

  localparam int unsigned LFSR_W      = 15;
  localparam int unsigned LFSR_TAP_HI = 14;
  localparam int unsigned LFSR_TAP_LO = 13;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  // Fibonacci step for x^15 + x^14 + 1; never maps a non-zero value to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter.sv
// Cascaded decimal counter: each enabled step adds one with ripple carry across digits.
module bcd_counter
  import reaction_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clkin,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      all_nines
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;

  logic [BCD_W-1:0] bcd_d;
  logic             carry;

  // Increment: a digit at 9 wraps to 0 and passes the carry upward.
  always_comb begin
    bcd_d = bcd;
    carry = en;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX) begin
          bcd_d[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          bcd_d[i*DIGIT_W +: DIGIT_W] = bcd[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] != DIGIT_MAX) all_nines = 1'b0;
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n || clr) bcd <= '0;
    else               bcd <= bcd_d;
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random tick delay, then light led and count ticks in BCD until stop.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned MIN_DELAY  = 1000,
  parameter int unsigned DELAY_MASK = 14'h0FFF,
  parameter int unsigned CNT_W      = 14
) (
  input  logic                      clkin,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      stop,
  output logic                      led,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      busy,
  output logic                      done,
  output logic                      early,
  output logic                      overflow
);

  // Load must fit the counter and be at least one tick so expiry at 1 is reachable.
  if (MIN_DELAY == 0 || 64'(MIN_DELAY) + 64'(DELAY_MASK) >= (64'd1 << CNT_W)) begin : g_cfg_check
    $error("reaction_timer: MIN_DELAY + DELAY_MASK must be in [1, 2**CNT_W)");
  end

  state_t            state, state_d;
  logic [CNT_W-1:0]  delay_cnt, delay_cnt_d;
  logic [LFSR_W-1:0] lfsr;
  logic              led_d, busy_d, done_d, early_d, overflow_d;
  logic              bcd_clr, bcd_en, all_nines;
  logic [CNT_W-1:0]  load_val;

  assign load_val = CNT_W'(MIN_DELAY) + (CNT_W'(lfsr[LFSR_W-2:0]) & CNT_W'(DELAY_MASK));

  bcd_counter #(
    .DIGITS(DIGITS)
  ) u_bcd (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .clr      (bcd_clr),
    .en       (bcd_en),
    .bcd      (bcd),
    .all_nines(all_nines)
  );

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state     <= IDLE;
      delay_cnt <= '0;
      lfsr      <= LFSR_SEED;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      early     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      delay_cnt <= delay_cnt_d;
      lfsr      <= lfsr_next(lfsr);
      led       <= led_d;
      busy      <= busy_d;
      done      <= done_d;
      early     <= early_d;
      overflow  <= overflow_d;
    end
  end

  // Next state; stop takes priority over a same-cycle tick in both active states.
  always_comb begin
    state_d     = state;
    delay_cnt_d = delay_cnt;
    overflow_d  = overflow;
    bcd_clr     = 1'b0;
    bcd_en      = 1'b0;

    unique case (state)
      IDLE, DONE, EARLY: begin
        if (start) begin
          state_d     = DELAY;
          delay_cnt_d = load_val;
          bcd_clr     = 1'b1;
          overflow_d  = 1'b0;
        end
      end
      DELAY: begin
        if (stop) begin
          state_d = EARLY;
        end else if (tick) begin
          delay_cnt_d = delay_cnt - CNT_W'(1);
          if (delay_cnt == CNT_W'(1)) state_d = TIMING;
        end
      end
      TIMING: begin
        if (stop) begin
          state_d = DONE;
        end else if (tick) begin
          if (all_nines) begin
            state_d    = DONE;
            overflow_d = 1'b1;
          end else begin
            bcd_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    led_d   = (state_d == TIMING);
    busy_d  = (state_d == DELAY) || (state_d == TIMING);
    done_d  = (state_d == DONE);
    early_d = (state_d == EARLY);
  end

endmodule
